// File: rtl/pipeline_pkg.sv
// Shared decode constants, instruction field positions and D/X control types
// for the D/X pipeline register and its instruction decoder.
package pipeline_pkg;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 17;
  localparam int RT_MSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int ALU_MSB = 6;
  localparam int ALU_LSB = 2;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [4:0] REG_RSTATUS = 5'd30;
  localparam logic [4:0] REG_RA      = 5'd31;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic is_add;
    logic is_addi;
    logic is_sub;
    logic is_and;
    logic is_or;
    logic is_sll;
    logic is_sra;
    logic is_mul;
    logic is_div;
    logic is_sw;
    logic is_lw;
    logic is_j;
    logic is_bne;
    logic is_blt;
    logic is_jal;
    logic is_jr;
    logic is_bex;
    logic is_setx;
  } dec_flags_t;

  // Which architectural registers an instruction reads in D (rstatus = implicit r30).
  typedef struct packed {
    logic rd;
    logic rs;
    logic rt;
    logic rstatus;
  } src_mask_t;

endpackage

// File: rtl/insn_decode.sv
// Combinational instruction decoder: one-hot class flags, register fields and
// the mask of registers the instruction reads.
module insn_decode
  import pipeline_pkg::*;
#(
  parameter int W_INSN = 32
) (
  input  logic [W_INSN-1:0] insn,
  output dec_flags_t        flags,
  output logic [4:0]        rd,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output src_mask_t         reads
);

  logic [4:0] op;
  logic [4:0] aluop;
  logic       unused_bits;

  assign op          = insn[OP_MSB:OP_LSB];
  assign aluop       = insn[ALU_MSB:ALU_LSB];
  assign rd          = insn[RD_MSB:RD_LSB];
  assign rs          = insn[RS_MSB:RS_LSB];
  assign rt          = insn[RT_MSB:RT_LSB];
  assign unused_bits = ^{insn[RT_LSB-1:ALU_MSB+1], insn[ALU_LSB-1:0]};

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    flags = '0;
    reads = '0;
    case (op)
      OP_RTYPE: begin
        case (aluop)
          ALU_ADD: flags.is_add = 1'b1;
          ALU_SUB: flags.is_sub = 1'b1;
          ALU_AND: flags.is_and = 1'b1;
          ALU_OR:  flags.is_or  = 1'b1;
          ALU_SLL: flags.is_sll = 1'b1;
          ALU_SRA: flags.is_sra = 1'b1;
          ALU_MUL: flags.is_mul = 1'b1;
          ALU_DIV: flags.is_div = 1'b1;
          default: ;
        endcase
        reads.rs = (flags != '0);
        reads.rt = (flags != '0) && !(flags.is_sll || flags.is_sra);
      end
      OP_J:    flags.is_j = 1'b1;
      OP_BNE:  begin flags.is_bne  = 1'b1; reads.rd = 1'b1; reads.rs = 1'b1; end
      OP_JAL:  flags.is_jal = 1'b1;
      OP_JR:   begin flags.is_jr   = 1'b1; reads.rd = 1'b1; end
      OP_ADDI: begin flags.is_addi = 1'b1; reads.rs = 1'b1; end
      OP_BLT:  begin flags.is_blt  = 1'b1; reads.rd = 1'b1; reads.rs = 1'b1; end
      OP_SW:   begin flags.is_sw   = 1'b1; reads.rd = 1'b1; reads.rs = 1'b1; end
      OP_LW:   begin flags.is_lw   = 1'b1; reads.rs = 1'b1; end
      OP_SETX: flags.is_setx = 1'b1;
      OP_BEX:  begin flags.is_bex  = 1'b1; reads.rstatus = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/dx_stage_reg.sv
// D/X pipeline register with decode, load-use bubble, flush squash and mul/div hold.
// Define DX_LW_SW_DATA_BYPASS_EN to let a store whose data reg alone matches a load skip the stall.
module dx_stage_reg
  import pipeline_pkg::*;
#(
  parameter int W_INSN = 32,
  parameter int W_PC   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [W_INSN-1:0] insn_fd,
  input  logic [W_PC-1:0]   pc_fd,
  input  logic              flush,
  input  logic              md_ready,
  output logic [W_INSN-1:0] insn_dx,
  output logic [W_PC-1:0]   pc_dx,
  output logic              valid_dx,
  output logic [4:0]        rd_dx,
  output logic [4:0]        rs_dx,
  output logic [4:0]        rt_dx,
  output logic              isAdd_dx,
  output logic              isAddi_dx,
  output logic              isSub_dx,
  output logic              isAnd_dx,
  output logic              isOr_dx,
  output logic              isSll_dx,
  output logic              isSra_dx,
  output logic              isMul_dx,
  output logic              isDiv_dx,
  output logic              isSw_dx,
  output logic              isLw_dx,
  output logic              isJ_dx,
  output logic              isBne_dx,
  output logic              isBlt_dx,
  output logic              isJal_dx,
  output logic              isJr_dx,
  output logic              isBex_dx,
  output logic              isSetx_dx,
  output logic              stall_fd,
  output logic              md_start_mult,
  output logic              md_start_div,
  output logic              md_busy
);

  logic [W_INSN-1:0] insn_q, insn_d;
  logic [W_PC-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              start_q, start_d;
  md_state_e         state_q, state_d;

  dec_flags_t dx_raw, dx_flags, fd_flags;
  src_mask_t  dx_reads, fd_reads;
  logic [4:0] fd_rd, fd_rs, fd_rt;
  logic       busy_hold, load_use, rd_hit;
  logic       unused_dx_reads;

  insn_decode #(.W_INSN(W_INSN)) u_dx_dec (
    .insn (insn_q), .flags (dx_raw), .rd (rd_dx), .rs (rs_dx), .rt (rt_dx), .reads (dx_reads)
  );

  insn_decode #(.W_INSN(W_INSN)) u_fd_dec (
    .insn (insn_fd), .flags (fd_flags), .rd (fd_rd), .rs (fd_rs), .rt (fd_rt), .reads (fd_reads)
  );

  // A bubble holds insn 0, which would otherwise decode as add.
  assign dx_flags        = valid_q ? dx_raw : '0;
  assign unused_dx_reads = ^dx_reads;

  // First BUSY cycle ignores md_ready so the start pulse always gets its own cycle.
  assign busy_hold = (state_q == S_BUSY) && (start_q || !md_ready);

  always_comb begin
    rd_hit = fd_reads.rd && (fd_rd == rd_dx);
`ifdef DX_LW_SW_DATA_BYPASS_EN
    if (fd_flags.is_sw) rd_hit = 1'b0;
`endif
    load_use = dx_flags.is_lw && (rd_dx != 5'd0) &&
               (rd_hit ||
                (fd_reads.rs && (fd_rs == rd_dx)) ||
                (fd_reads.rt && (fd_rt == rd_dx)) ||
                (fd_reads.rstatus && (rd_dx == REG_RSTATUS)));
  end

  always_comb begin
    insn_d  = insn_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    state_d = state_q;
    start_d = 1'b0;
    if (flush) begin
      insn_d  = '0;
      pc_d    = '0;
      valid_d = 1'b0;
      state_d = S_IDLE;
    end else if (busy_hold) begin
      state_d = S_BUSY;
    end else if (load_use) begin
      insn_d  = '0;
      pc_d    = '0;
      valid_d = 1'b0;
      state_d = S_IDLE;
    end else begin
      insn_d  = insn_fd;
      pc_d    = pc_fd;
      valid_d = 1'b1;
      if (fd_flags.is_mul || fd_flags.is_div) begin
        state_d = S_BUSY;
        start_d = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      insn_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      insn_q  <= insn_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      start_q <= start_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    md_busy       = (state_q == S_BUSY);
    md_start_mult = start_q && dx_flags.is_mul && !flush;
    md_start_div  = start_q && dx_flags.is_div && !flush;
    stall_fd      = !flush && (busy_hold || load_use);
  end

  assign insn_dx   = insn_q;
  assign pc_dx     = pc_q;
  assign valid_dx  = valid_q;
  assign isAdd_dx  = dx_flags.is_add;
  assign isAddi_dx = dx_flags.is_addi;
  assign isSub_dx  = dx_flags.is_sub;
  assign isAnd_dx  = dx_flags.is_and;
  assign isOr_dx   = dx_flags.is_or;
  assign isSll_dx  = dx_flags.is_sll;
  assign isSra_dx  = dx_flags.is_sra;
  assign isMul_dx  = dx_flags.is_mul;
  assign isDiv_dx  = dx_flags.is_div;
  assign isSw_dx   = dx_flags.is_sw;
  assign isLw_dx   = dx_flags.is_lw;
  assign isJ_dx    = dx_flags.is_j;
  assign isBne_dx  = dx_flags.is_bne;
  assign isBlt_dx  = dx_flags.is_blt;
  assign isJal_dx  = dx_flags.is_jal;
  assign isJr_dx   = dx_flags.is_jr;
  assign isBex_dx  = dx_flags.is_bex;
  assign isSetx_dx = dx_flags.is_setx;

endmodule

// File: tb/tb_dx_stage_reg.sv
// Self-checking bench for dx_stage_reg: directed hazard/mul-div/flush scenarios,
// then random instruction streams against an instruction-level reference model.
module tb_dx_stage_reg;

  logic        clock = 1'b0;
  logic        reset, flush, md_ready;
  logic [31:0] insn_fd, pc_fd, insn_dx, pc_dx;
  logic        valid_dx;
  logic [4:0]  rd_dx, rs_dx, rt_dx;
  logic isAdd_dx, isAddi_dx, isSub_dx, isAnd_dx, isOr_dx, isSll_dx, isSra_dx, isMul_dx, isDiv_dx;
  logic isSw_dx, isLw_dx, isJ_dx, isBne_dx, isBlt_dx, isJal_dx, isJr_dx, isBex_dx, isSetx_dx;
  logic stall_fd, md_start_mult, md_start_div, md_busy;

  dx_stage_reg dut (
    .clock(clock), .reset(reset), .insn_fd(insn_fd), .pc_fd(pc_fd), .flush(flush),
    .md_ready(md_ready), .insn_dx(insn_dx), .pc_dx(pc_dx), .valid_dx(valid_dx),
    .rd_dx(rd_dx), .rs_dx(rs_dx), .rt_dx(rt_dx),
    .isAdd_dx(isAdd_dx), .isAddi_dx(isAddi_dx), .isSub_dx(isSub_dx), .isAnd_dx(isAnd_dx),
    .isOr_dx(isOr_dx), .isSll_dx(isSll_dx), .isSra_dx(isSra_dx), .isMul_dx(isMul_dx),
    .isDiv_dx(isDiv_dx), .isSw_dx(isSw_dx), .isLw_dx(isLw_dx), .isJ_dx(isJ_dx),
    .isBne_dx(isBne_dx), .isBlt_dx(isBlt_dx), .isJal_dx(isJal_dx), .isJr_dx(isJr_dx),
    .isBex_dx(isBex_dx), .isSetx_dx(isSetx_dx), .stall_fd(stall_fd),
    .md_start_mult(md_start_mult), .md_start_div(md_start_div), .md_busy(md_busy)
  );

  always #5 clock = ~clock;

`ifdef DX_LW_SW_DATA_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam int K_ADD = 0,  K_ADDI = 1,  K_SUB = 2,  K_AND = 3,  K_OR = 4,   K_SLL = 5;
  localparam int K_SRA = 6,  K_MUL = 7,   K_DIV = 8,  K_SW = 9,   K_LW = 10,  K_J = 11;
  localparam int K_BNE = 12, K_BLT = 13,  K_JAL = 14, K_JR = 15,  K_BEX = 16, K_SETX = 17;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: what D/X holds and how long a mul/div has been in X.
  logic        m_valid, m_busy;
  logic [31:0] m_insn, m_pc;
  int          m_age;
  int          pc_ctr = 32'h100;
  logic        obs_stall, obs_smul, obs_sdiv;
  logic        exp_stall_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input int alu, input int rd, input int rs, input int rt);
    logic [31:0] w;
    w = '0;
    w[26:22] = 5'(rd); w[21:17] = 5'(rs); w[16:12] = 5'(rt); w[6:2] = 5'(alu);
    return w;
  endfunction

  function automatic logic [31:0] mk_i(input int op, input int rd, input int rs, input int imm);
    logic [31:0] w;
    w = '0;
    w[31:27] = 5'(op); w[26:22] = 5'(rd); w[21:17] = 5'(rs); w[16:0] = 17'(imm);
    return w;
  endfunction

  // Instruction class from the opcode table; -1 for anything unrecognised.
  function automatic int kind(input logic [31:0] w);
    int k;
    k = -1;
    case (w[31:27])
      5'd0: case (w[6:2])
              5'd0: k = K_ADD;  5'd1: k = K_SUB;  5'd2: k = K_AND;  5'd3: k = K_OR;
              5'd4: k = K_SLL;  5'd5: k = K_SRA;  5'd6: k = K_MUL;  5'd7: k = K_DIV;
              default: k = -1;
            endcase
      5'd1:  k = K_J;    5'd2:  k = K_BNE;  5'd3:  k = K_JAL;  5'd4: k = K_JR;
      5'd5:  k = K_ADDI; 5'd6:  k = K_BLT;  5'd7:  k = K_SW;   5'd8: k = K_LW;
      5'd21: k = K_SETX; 5'd22: k = K_BEX;
      default: k = -1;
    endcase
    return k;
  endfunction

  function automatic bit reads_reg(input logic [31:0] w, input logic [4:0] r);
    logic [4:0] rd, rs, rt;
    bit hit;
    rd = w[26:22]; rs = w[21:17]; rt = w[16:12];
    case (kind(w))
      K_ADD, K_SUB, K_AND, K_OR, K_MUL, K_DIV: hit = (r == rs) || (r == rt);
      K_SLL, K_SRA, K_ADDI, K_LW:              hit = (r == rs);
      K_SW:                                    hit = (r == rs) || ((r == rd) && !BYPASS);
      K_BNE, K_BLT:                            hit = (r == rd) || (r == rs);
      K_JR:                                    hit = (r == rd);
      K_BEX:                                   hit = (r == 5'd30);
      default:                                 hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic [4:0] pick_reg();
    logic [4:0] r;
    case ($urandom_range(0, 4))
      0: r = 5'd0;  1: r = 5'd1;  2: r = 5'd5;  3: r = 5'd30;  default: r = 5'd31;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    int sel;
    w = $urandom;
    w[26:22] = pick_reg(); w[21:17] = pick_reg(); w[16:12] = pick_reg();
    sel = $urandom_range(0, 16);
    case (sel)
      0, 1, 2, 3: begin w[31:27] = 5'd0; w[6:2] = 5'($urandom_range(0, 9)); end
      4:  w[31:27] = 5'd1;   5:  w[31:27] = 5'd2;   6:  w[31:27] = 5'd3;
      7:  w[31:27] = 5'd4;   8:  w[31:27] = 5'd5;   9:  w[31:27] = 5'd6;
      10: w[31:27] = 5'd7;   11: w[31:27] = 5'd8;   12: w[31:27] = 5'd8;
      13: w[31:27] = 5'd21;  14: w[31:27] = 5'd22;  default: w[31:27] = 5'd31;
    endcase
    return w;
  endfunction

  function automatic logic [17:0] dut_flags();
    return {isAdd_dx, isAddi_dx, isSub_dx, isAnd_dx, isOr_dx, isSll_dx, isSra_dx, isMul_dx,
            isDiv_dx, isSw_dx, isLw_dx, isJ_dx, isBne_dx, isBlt_dx, isJal_dx, isJr_dx,
            isBex_dx, isSetx_dx};
  endfunction

  // One clock cycle: drive at the falling edge, check, then advance the model past the rising edge.
  task automatic step(input logic [31:0] insn, input logic fl, input logic rdy);
    bit          hold, haz;
    int          k;
    logic [17:0] e_flags;
    logic [31:0] pc;
    @(negedge clock);
    pc = 32'(pc_ctr);
    pc_ctr++;
    insn_fd = insn; pc_fd = pc; flush = fl; md_ready = rdy;
    #1;
    k       = kind(m_insn);
    hold    = m_busy && ((m_age == 0) || !rdy);
    haz     = m_valid && (k == K_LW) && (m_insn[26:22] != 5'd0) && reads_reg(insn, m_insn[26:22]);
    e_flags = (m_valid && k >= 0) ? (18'h20000 >> k) : 18'h0;
    check("insn_dx",  insn_dx, m_insn);
    check("pc_dx",    pc_dx, m_pc);
    check("valid_dx", 32'(valid_dx), 32'(m_valid));
    check("rd_dx",    32'(rd_dx), 32'(m_insn[26:22]));
    check("rs_dx",    32'(rs_dx), 32'(m_insn[21:17]));
    check("rt_dx",    32'(rt_dx), 32'(m_insn[16:12]));
    check("flags",    32'(dut_flags()), 32'(e_flags));
    check("stall_fd", 32'(stall_fd), 32'(!fl && (hold || haz)));
    check("md_start_mult", 32'(md_start_mult), 32'(m_busy && m_age == 0 && k == K_MUL && !fl));
    check("md_start_div",  32'(md_start_div),  32'(m_busy && m_age == 0 && k == K_DIV && !fl));
    check("md_busy",  32'(md_busy), 32'(m_busy));
    obs_stall = stall_fd; obs_smul = md_start_mult; obs_sdiv = md_start_div;
    exp_stall_last = !fl && (hold || haz);
    @(posedge clock);
    if (fl) begin
      m_valid = 1'b0; m_insn = '0; m_pc = '0; m_busy = 1'b0;
    end else if (hold) begin
      m_age++;
    end else if (haz) begin
      m_valid = 1'b0; m_insn = '0; m_pc = '0; m_busy = 1'b0;
    end else begin
      m_valid = 1'b1; m_insn = insn; m_pc = pc;
      m_busy  = (kind(insn) == K_MUL) || (kind(insn) == K_DIV);
      m_age   = 0;
    end
  endtask

  initial begin
    int pulses, stalls;
    logic [31:0] cur;
    logic fl, rdy;

    // 1: reset held three cycles with an add waiting in F/D
    reset = 1'b1; flush = 1'b0; md_ready = 1'b0;
    insn_fd = mk_r(0, 1, 2, 3); pc_fd = 32'h40;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    check("rst_insn_dx", insn_dx, 32'h0);
    check("rst_pc_dx", pc_dx, 32'h0);
    check("rst_valid", 32'(valid_dx), 32'h0);
    check("rst_flags", 32'(dut_flags()), 32'h0);
    check("rst_fields", 32'({rd_dx, rs_dx, rt_dx}), 32'h0);
    check("rst_stall", 32'(stall_fd), 32'h0);
    check("rst_starts", 32'({md_start_mult, md_start_div}), 32'h0);
    check("rst_busy", 32'(md_busy), 32'h0);
    m_valid = 1'b0; m_busy = 1'b0; m_insn = '0; m_pc = '0; m_age = 0;
    @(posedge clock); #1;
    reset = 1'b0;

    // 2: lw r5 then a dependent add -> exactly one bubble
    step(mk_i(8, 5, 1, 0), 0, 0);
    step(mk_r(0, 6, 5, 2), 0, 0);
    check("t2_stall", 32'(obs_stall), 32'h1);
    #1 check("t2_bubble", 32'(valid_dx), 32'h0);
    step(mk_r(0, 6, 5, 2), 0, 0);
    check("t2_single_bubble", 32'(obs_stall), 32'h0);
    #1 check("t2_add_in", insn_dx, mk_r(0, 6, 5, 2));

    // 3: load to r0 never stalls; load to r30 stalls bex once
    step(mk_i(8, 0, 1, 4), 0, 0);
    step(mk_r(0, 6, 0, 2), 0, 0);
    check("t3_r0_no_stall", 32'(obs_stall), 32'h0);
    step(mk_i(8, 30, 1, 0), 0, 0);
    step(mk_i(22, 0, 0, 16), 0, 0);
    check("t3_bex_stall", 32'(obs_stall), 32'h1);
    step(mk_i(22, 0, 0, 16), 0, 0);
    check("t3_bex_go", 32'(obs_stall), 32'h0);

    // 4: mul held four cycles, then back-to-back div
    step(mk_r(6, 3, 1, 2), 0, 0);
    pulses = 0; stalls = 0;
    for (int i = 0; i < 4; i++) begin
      step(mk_r(0, 7, 3, 4), 0, 0);
      pulses += int'(obs_smul);
      stalls += int'(obs_stall);
    end
    check("t4_mult_pulses", 32'(pulses), 32'd1);
    check("t4_stall_cycles", 32'(stalls), 32'd4);
    step(mk_r(7, 8, 1, 2), 0, 1);
    check("t4_ready_accepts", 32'(obs_stall), 32'h0);
    step(mk_r(0, 7, 3, 4), 0, 1);
    check("t4_div_pulse", 32'(obs_sdiv), 32'h1);
    check("t4_ready_ignored", 32'(obs_stall), 32'h1);
    step(mk_r(0, 7, 3, 4), 0, 1);
    #1 check("t4_next_in", insn_dx, mk_r(0, 7, 3, 4));

    // 5: flush while BUSY, in the start cycle, and during a load-use stall
    step(mk_r(6, 3, 1, 2), 0, 0);
    step(mk_r(0, 7, 1, 4), 0, 0);
    step(mk_r(0, 7, 1, 4), 1, 0);
    check("t5_busy_flush_stall", 32'(obs_stall), 32'h0);
    #1 check("t5_busy_flush_idle", 32'({md_busy, valid_dx}), 32'h0);
    step(mk_r(7, 8, 1, 2), 0, 0);
    step(mk_r(0, 7, 1, 4), 1, 0);
    check("t5_no_start_on_flush", 32'(obs_sdiv), 32'h0);
    #1 check("t5_start_flush_idle", 32'(md_busy), 32'h0);
    step(mk_i(8, 5, 1, 0), 0, 0);
    step(mk_r(0, 6, 5, 2), 1, 0);
    check("t5_lu_flush_stall", 32'(obs_stall), 32'h0);
    #1 check("t5_lu_flush_bubble", 32'(valid_dx), 32'h0);

    // 6: lw r5 then sw r5,0(r2): stall only without the store-data bypass
    step(mk_i(8, 5, 1, 0), 0, 0);
    step(mk_i(7, 5, 2, 0), 0, 0);
    check("t6_lw_sw", 32'(obs_stall), 32'(!BYPASS));

    // Random instruction stream; F/D holds its instruction while stalled
    cur = rand_insn();
    for (int i = 0; i < 600; i++) begin
      if (!exp_stall_last) cur = rand_insn();
      fl  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      step(cur, fl, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
